com_uart: RTL and testbench

- Serial-port peripheral at the far end of the memory controller's COM interface.
- Accepts byte-write strobes from the controller and shifts them out as 8N1 frames on txd.
- Deserialises 8N1 frames from rxd and presents each byte with a read-ready flag, which the controller clears with its read acknowledge.
- Sits between the memory controller and the board RS-232 pins; supplies com_data_in, com_read_ready and com_write_ready.

---
 rtl/com_pkg.sv | 19 +
 rtl/com_uart_tx.sv | 78 +++++++
 rtl/com_uart.sv | 119 +++++++++++
 tb/tb_com_uart.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/com_pkg.sv
// Shared definitions for the COM serial port: FSM states, frame constants and
// the bit-timer width helper.
package com_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } com_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    function automatic int unsigned cnt_w(input int unsigned clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/com_uart_tx.sv
// 8N1 transmitter: latches a byte on the write strobe and shifts it out LSB
// first on a registered txd line.
module com_uart_tx
    import com_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic [7:0] com_data_out,
    input  logic       enable_com_write,
    output logic       com_write_ready,
    output logic       txd
);

    localparam int unsigned CNT_W = cnt_w(CLKS_PER_BIT);

    com_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            shreg           <= '0;
            txd             <= 1'b1;
            com_write_ready <= 1'b1;
        end else if (state == ST_IDLE) begin
            if (enable_com_write) begin
                shreg           <= com_data_out;
                txd             <= 1'b0;
                com_write_ready <= 1'b0;
                cnt             <= '0;
                state           <= ST_START;
            end
        end else if (!bit_end) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            // Timer reloads on every bit boundary so frame length is exact.
            cnt <= '0;
            case (state)
                ST_START: begin
                    txd     <= shreg[0];
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= '0;
                    state   <= ST_DATA;
                end
                ST_DATA: begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        txd     <= 1'b1;
                        bit_idx <= '0;
                        state   <= ST_STOP;
                    end else begin
                        txd     <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_idx == 3'(STOP_BITS - 1)) begin
                        com_write_ready <= 1'b1;
                        state           <= ST_IDLE;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/com_uart.sv
// COM-interface UART: transmitter sub-block plus the synchronised 8N1
// receiver with read-ready, overrun and framing-error flags.
module com_uart
    import com_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic [7:0] com_data_out,
    input  logic       enable_com_write,
    output logic       com_write_ready,
    output logic [7:0] com_data_in,
    output logic       com_read_ready,
    input  logic       int_com_ack,
    input  logic       rxd,
    output logic       txd,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int unsigned CNT_W = cnt_w(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    com_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk50M          (clk50M),
        .rst_n           (rst_n),
        .com_data_out    (com_data_out),
        .enable_com_write(enable_com_write),
        .com_write_ready (com_write_ready),
        .txd             (txd)
    );

    logic             rx_meta, rx_sync;
    com_state_t       rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;
    logic             bit_end, half_end;

    assign bit_end  = (rx_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign half_end = (rx_cnt == CNT_W'(HALF - 1));

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_state       <= ST_IDLE;
            rx_cnt         <= '0;
            rx_idx         <= '0;
            rx_shift       <= '0;
            com_data_in    <= '0;
            com_read_ready <= 1'b0;
            rx_frame_err   <= 1'b0;
            rx_overrun     <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            if (int_com_ack) com_read_ready <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (half_end) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                        if (rx_idx == 3'(DATA_BITS - 1)) rx_state <= ST_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
                        // A completing byte overrides a coincident acknowledge.
                        if (rx_sync) begin
                            com_data_in    <= rx_shift;
                            com_read_ready <= 1'b1;
                            rx_overrun     <= com_read_ready & ~int_com_ack;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_com_uart.sv
// Directed self-checking bench for com_uart at 16 clocks per bit.
module tb_com_uart;

    logic       clk50M = 1'b0;
    logic       rst_n;
    logic [7:0] com_data_out;
    logic       enable_com_write;
    logic       com_write_ready;
    logic [7:0] com_data_in;
    logic       com_read_ready;
    logic       int_com_ack;
    logic       rxd;
    logic       rxd_drv;
    logic       loop_en;
    logic       txd;
    logic       rx_frame_err;
    logic       rx_overrun;

    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;
    int ferr_cnt = 0;
    logic [9:0] frame;

    assign rxd = loop_en ? txd : rxd_drv;

    always #5 clk50M = ~clk50M;

    com_uart #(
        .CLKS_PER_BIT(16)
    ) dut (
        .clk50M          (clk50M),
        .rst_n           (rst_n),
        .com_data_out    (com_data_out),
        .enable_com_write(enable_com_write),
        .com_write_ready (com_write_ready),
        .com_data_in     (com_data_in),
        .com_read_ready  (com_read_ready),
        .int_com_ack     (int_com_ack),
        .rxd             (rxd),
        .txd             (txd),
        .rx_frame_err    (rx_frame_err),
        .rx_overrun      (rx_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk50M);
            #1;
            ovr_cnt  += int'(rx_overrun);
            ferr_cnt += int'(rx_frame_err);
        end
    endtask

    task automatic clear_flags();
        ovr_cnt  = 0;
        ferr_cnt = 0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input logic ack_at_stop);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int t = 0; t < 160; t++) begin
            rxd_drv = bits[t/16];
            if (ack_at_stop) int_com_ack = (t == 154);
            adv(1);
        end
        rxd_drv     = 1'b1;
        int_com_ack = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        com_data_out     = '0;
        enable_com_write = 1'b0;
        int_com_ack      = 1'b0;
        rxd_drv          = 1'b1;
        loop_en          = 1'b0;

        repeat (3) @(posedge clk50M);
        #1;
        check("rst_txd", txd, 1);
        check("rst_wr_ready", com_write_ready, 1);
        check("rst_rd_ready", com_read_ready, 0);
        check("rst_data_in", com_data_in, 0);
        check("rst_ferr", rx_frame_err, 0);
        check("rst_ovr", rx_overrun, 0);
        rst_n = 1'b1;
        adv(3);

        // TX frame of A5 with an ignored 3C strobe at cycle 50
        frame = {1'b1, 8'hA5, 1'b0};
        com_data_out     = 8'hA5;
        enable_com_write = 1'b1;
        adv(1);
        enable_com_write = 1'b0;
        check("tx_start_txd", txd, 0);
        check("tx_start_ready", com_write_ready, 0);
        clear_flags();
        for (int t = 1; t <= 160; t++) begin
            adv(1);
            if (t < 160 && (t % 16 == 0 || t % 16 == 15))
                check($sformatf("tx_bit_t%0d", t), txd, frame[t/16]);
            if (t == 1 || t == 159)
                check($sformatf("tx_busy_t%0d", t), com_write_ready, 0);
            if (t == 49) begin
                com_data_out     = 8'h3C;
                enable_com_write = 1'b1;
            end
            if (t == 50) enable_com_write = 1'b0;
        end
        check("tx_ready_160", com_write_ready, 1);
        check("tx_idle_160", txd, 1);
        for (int t = 0; t < 40; t++) begin
            adv(1);
            if (t % 8 == 7) begin
                check($sformatf("tx_no2nd_txd_%0d", t), txd, 1);
                check($sformatf("tx_no2nd_rdy_%0d", t), com_write_ready, 1);
            end
        end

        // RX byte plus acknowledge
        clear_flags();
        send_rx(8'h5A, 1'b1, 1'b0);
        check("rx5a_data", com_data_in, 8'h5A);
        check("rx5a_ready", com_read_ready, 1);
        check("rx5a_flags", ovr_cnt + ferr_cnt, 0);
        int_com_ack = 1'b1;
        adv(1);
        check("ack_ready", com_read_ready, 0);
        check("ack_data", com_data_in, 8'h5A);
        adv(3);
        int_com_ack = 1'b0;
        check("ack_hold_ready", com_read_ready, 0);
        check("ack_hold_data", com_data_in, 8'h5A);
        adv(4);

        // Overrun, then acknowledge colliding with the stop sample
        clear_flags();
        send_rx(8'h11, 1'b1, 1'b0);
        check("rx11_data", com_data_in, 8'h11);
        check("rx11_ovr", ovr_cnt, 0);
        send_rx(8'h22, 1'b1, 1'b0);
        check("rx22_data", com_data_in, 8'h22);
        check("rx22_ready", com_read_ready, 1);
        check("rx22_ovr", ovr_cnt, 1);
        clear_flags();
        send_rx(8'h33, 1'b1, 1'b1);
        check("coll_data", com_data_in, 8'h33);
        check("coll_ready", com_read_ready, 1);
        check("coll_ovr", ovr_cnt, 0);
        int_com_ack = 1'b1;
        adv(1);
        int_com_ack = 1'b0;
        check("coll_ack_ready", com_read_ready, 0);

        // Start-bit glitch is rejected; a following frame still lands
        clear_flags();
        rxd_drv = 1'b0;
        adv(5);
        rxd_drv = 1'b1;
        adv(40);
        check("glitch_flags", ovr_cnt + ferr_cnt, 0);
        check("glitch_ready", com_read_ready, 0);
        check("glitch_data", com_data_in, 8'h33);
        send_rx(8'h96, 1'b1, 1'b0);
        check("post_glitch_data", com_data_in, 8'h96);
        check("post_glitch_ready", com_read_ready, 1);

        // Framing error leaves held byte and ready untouched
        clear_flags();
        send_rx(8'hFF, 1'b0, 1'b0);
        adv(30);
        check("ferr_cnt", ferr_cnt, 1);
        check("ferr_ovr", ovr_cnt, 0);
        check("ferr_data", com_data_in, 8'h96);
        check("ferr_ready", com_read_ready, 1);

        // Reset mid-frame: TX in data bit 3 (A5 bit3 = 0), RX in data bit 4
        frame = {1'b1, 8'h69, 1'b0};
        for (int t = 0; t < 88; t++) begin
            rxd_drv = frame[t/16];
            if (t == 16) begin
                com_data_out     = 8'hA5;
                enable_com_write = 1'b1;
            end
            if (t == 17) enable_com_write = 1'b0;
            adv(1);
        end
        check("pre_rst_txd", txd, 0);
        check("pre_rst_busy", com_write_ready, 0);
        rst_n = 1'b0;
        #2;
        check("async_rst_txd", txd, 1);
        check("async_rst_wr_ready", com_write_ready, 1);
        check("async_rst_rd_ready", com_read_ready, 0);
        check("async_rst_data", com_data_in, 0);
        rxd_drv = 1'b1;
        adv(2);
        rst_n = 1'b1;
        adv(3);

        // Loopback of C3
        clear_flags();
        loop_en          = 1'b1;
        com_data_out     = 8'hC3;
        enable_com_write = 1'b1;
        adv(1);
        enable_com_write = 1'b0;
        adv(200);
        check("loop_data", com_data_in, 8'hC3);
        check("loop_ready", com_read_ready, 1);
        check("loop_flags", ovr_cnt + ferr_cnt, 0);
        check("loop_wr_ready", com_write_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
